// File: rtl/ahb_pkg.sv
// Shared AHB arbiter definitions: transfer codes, master IDs, grant-state enum.
package ahb_pkg;

    localparam int unsigned HTRANS_W  = 2;
    localparam int unsigned HMASTER_W = 4;
    localparam int unsigned HOLD_W    = 8;

    typedef enum logic [HTRANS_W-1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [HMASTER_W-1:0] MST_M1 = 4'd1;
    localparam logic [HMASTER_W-1:0] MST_M2 = 4'd2;

    typedef enum logic {
        GNT_M1 = 1'b0,
        GNT_M2 = 1'b1
    } gnt_state_t;

    // Master ID presented on HMASTER for a given grant state.
    function automatic logic [HMASTER_W-1:0] mst_id(input gnt_state_t s);
        return (s == GNT_M2) ? MST_M2 : MST_M1;
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter-facing AHB signal bundle; slave = arbiter side, master = requesters side.
interface ahb_arbiter_if;
    import ahb_pkg::*;

    logic                 HBUSREQ_M1;
    logic                 HBUSREQ_M2;
    logic                 HLOCK_M1;
    logic                 HLOCK_M2;
    logic [HTRANS_W-1:0]  HTRANS;
    logic                 HREADY;
    logic                 HGRANT_M1;
    logic                 HGRANT_M2;
    logic [HMASTER_W-1:0] HMASTER;
    logic                 HMASTLOCK;

    modport slave (
        input  HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HTRANS, HREADY,
        output HGRANT_M1, HGRANT_M2, HMASTER, HMASTLOCK
    );

    modport master (
        output HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HTRANS, HREADY,
        input  HGRANT_M1, HGRANT_M2, HMASTER, HMASTLOCK
    );

endinterface

// File: rtl/ahb_hold_timer.sv
// Saturating hold counter: counts cycles the owner keeps the bus against a waiting requester.
module ahb_hold_timer
    import ahb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != HOLD_MAX)) begin
            count <= count + HOLD_W'(1);
        end
    end

    assign expired_c = (count == HOLD_MAX);

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter (M1 fetch, M2 data) with lock, burst and hold-limit handling.
// Define ARB_RR_EN for round-robin tie-break; default is fixed priority M2 over M1.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_arbiter_if.slave bus
);

    gnt_state_t state;
    gnt_state_t state_nxt;
    gnt_state_t other_state;
    gnt_state_t tie_winner;
    logic       owner_lock;
    logic       other_req;
    logic       seq_burst;
    logic       hold_inc;
    logic       hold_clr;
    logic       hold_expired;

    // Owner-relative view of the requests.
    always_comb begin
        owner_lock  = (state == GNT_M1) ? bus.HLOCK_M1   : bus.HLOCK_M2;
        other_req   = (state == GNT_M1) ? bus.HBUSREQ_M2 : bus.HBUSREQ_M1;
        other_state = (state == GNT_M1) ? GNT_M2 : GNT_M1;
        seq_burst   = (htrans_t'(bus.HTRANS) == SEQ);
    end

`ifdef ARB_RR_EN
    gnt_state_t rr_last;

    // Last granted master; the other one wins a tie.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_last <= GNT_M1;
        end else if (state_nxt != state) begin
            rr_last <= state_nxt;
        end
    end

    assign tie_winner = (rr_last == GNT_M1) ? GNT_M2 : GNT_M1;
`else
    assign tie_winner = GNT_M2;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= GNT_M1;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock beats everything; hold expiry beats an ongoing SEQ burst.
    always_comb begin
        state_nxt = state;
        if (bus.HREADY && !owner_lock) begin
            if (hold_expired && other_req) begin
                state_nxt = other_state;
            end else if (!seq_burst) begin
                unique case ({bus.HBUSREQ_M1, bus.HBUSREQ_M2})
                    2'b10:   state_nxt = GNT_M1;
                    2'b01:   state_nxt = GNT_M2;
                    2'b11:   state_nxt = tie_winner;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_comb begin
        bus.HGRANT_M1 = 1'b0;
        bus.HGRANT_M2 = 1'b0;
        if (state == GNT_M2) begin
            bus.HGRANT_M2 = 1'b1;
        end else begin
            bus.HGRANT_M1 = 1'b1;
        end
    end

    assign hold_clr = (state_nxt != state);
    assign hold_inc = bus.HREADY && !owner_lock && other_req;

    ahb_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .clr       (hold_clr),
        .inc       (hold_inc),
        .expired_c (hold_expired)
    );

    // Address-phase owner trails the grant by one completed transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus.HMASTER   <= MST_M1;
            bus.HMASTLOCK <= 1'b0;
        end else if (bus.HREADY) begin
            bus.HMASTER   <= mst_id(state);
            bus.HMASTLOCK <= owner_lock;
        end
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Two-master arbiter for the system AHB bus. It decides each cycle which master owns the address bus: M1 is the instruction-fetch wrapper and M2 is the data-memory wrapper. It drives the per-master grants and the registered HMASTER/HMASTLOCK used by the address/data multiplexers and slave select. It honours locked transfers and undisturbed bursts, and bounds how long one master can hold the bus against a waiting requester.

## Interface
- MAX_HOLD, default 16: cycles an unlocked owner may keep the bus while the other master requests; range 2..255.
- HCLK  input  1  bus clock; all state changes on the rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HBUSREQ_M1  input  1  bus request, master 1.
- HBUSREQ_M2  input  1  bus request, master 2.
- HLOCK_M1  input  1  locked-transfer request, master 1.
- HLOCK_M2  input  1  locked-transfer request, master 2.
- HTRANS  input  2  muxed transfer type of the current address phase.
- HREADY  input  1  muxed slave ready; 1 = the current transfer completes this cycle.
- HGRANT_M1  output  1  master 1 owns the next address phase.
- HGRANT_M2  output  1  master 2 owns the next address phase.
- HMASTER  output  4  owner of the current address phase: 4'd1 = M1, 4'd2 = M2; no other values are driven.
- HMASTLOCK  output  1  the current address phase is locked.

## Operation
- Grant FSM has two states, GNT_M1 and GNT_M2. GNT_M1 is the default master state.
- HGRANT_Mx is decoded from the state and is one-hot at all times.
- Arbitration is evaluated only in cycles with HREADY = 1. With HREADY = 0, the state, HMASTER, HMASTLOCK and the hold count are all frozen.
- Re-arbitration is blocked when the owner has HLOCK asserted, or when HTRANS = SEQ, except on hold expiry (below).
- Locked ownership can never be pre-empted, including on hold expiry.
- Otherwise the next owner is chosen as follows:
  - Only one master requesting: that master.
  - Neither master requesting: stay in the current state (bus parking).
  - Both requesting: resolved by priority (see Configuration).
- Hold counter, 8 bits:
  - Clears on every grant change.
  - Increments in HREADY cycles while the owner is unlocked and the non-owner requests; saturates at MAX_HOLD.
  - When it reaches MAX_HOLD, the grant moves to the waiting master at the next HREADY cycle, even mid-burst (HTRANS = SEQ).
- HMASTER is loaded from the granted ID on each HREADY cycle, so it trails the grant by one transfer (address-phase ownership).
- HMASTLOCK is loaded on each HREADY cycle from the HLOCK of the granted master.

## Timing
- Reset values: HGRANT_M1 = 1, HGRANT_M2 = 0, HMASTER = 4'd1, HMASTLOCK = 0, hold count = 0, state GNT_M1, RR pointer = M1.
- Reset assertion mid-transfer forces the reset values immediately, without waiting for a clock edge.
- Grant latency is one cycle: a request sampled at edge N with HREADY = 1 gives HGRANT high after edge N.
- HMASTER switches at the first HREADY = 1 edge after the grant change, so switching takes at least two edges.
- Simultaneous requests in the same cycle are resolved by priority; there is no grant glitch and no cycle with zero or two grants.
- A requester that drops its request before being granted is not granted.
- An owner that drops its request loses the grant only when the other master requests.
- HREADY held low for many cycles leaves all outputs unchanged and the hold count unchanged.

## Configuration
- ARB_RR_EN defined: round-robin priority. On a tie, the master not granted last wins. The RR pointer updates on each grant change.
- ARB_RR_EN undefined: fixed priority, M2 (data) over M1 (fetch). The pointer logic is removed.
- The hold-expiry behaviour is present in both builds.

## Structure
- Shared package ahb_pkg holds:
  - the HTRANS codes IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  - the master ID constants MST_M1 = 4'd1, MST_M2 = 4'd2;
  - the grant-state enum {GNT_M1, GNT_M2}.
- One sub-module, ahb_hold_timer, contains the saturating hold counter with clear, increment and expired outputs.
- The FSM, the priority logic and the HMASTER/HMASTLOCK registers stay in ahb_arbiter.

## Test plan
- Reset: with HRESETn low, check HGRANT_M1 = 1, HGRANT_M2 = 0, HMASTER = 1, HMASTLOCK = 0. Release reset with no requests: the grant stays with M1.
- Single request: M2 requests with HTRANS = NONSEQ and HREADY = 1. HGRANT_M2 = 1 after the next edge, and HMASTER = 2 one HREADY edge later.
- Simultaneous requests from state GNT_M1:
  - Fixed-priority build: M2 is granted.
  - ARB_RR_EN build: M2 is granted first. After M2 drops its request with M1 still requesting, M1 is granted. If both then re-request together, M2 is granted.
- Lock: M1 owns the bus with HLOCK_M1 = 1 and M2 requests for 40 cycles. The grant stays M1 and HMASTLOCK = 1. Deassert HLOCK_M1: M2 is granted on the next HREADY edge.
- Hold expiry with MAX_HOLD = 4: M1 runs an unlocked SEQ burst while M2 requests. After 4 HREADY cycles the grant moves to M2 mid-burst.
- HREADY stall: with HREADY = 0 for 10 cycles while M2 requests, all outputs stay constant. Raise HREADY: the grant moves after 1 edge.
